atx_status_reporter: RTL and testbench

SPI-side status read-back stage paired with the ATX command decoder, running on the host SPI clock while the iCE is held in reset. It hunts the host bit stream for a dedicated status-read preamble and answers with a 16-bit status frame on sdo. The frame carries the decoder state, rail status, iCE done and a clear-on-read watchdog event count. Once the iCE leaves reset, the SPI bus belongs to the iCE and this block is held in reset.

---
 rtl/atx_status_reporter.sv | 141 ++++++++++++++
 tb/tb_atx_status_reporter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/atx_status_reporter.sv
// -----------------------------------------------------------------------------
// atx_status_reporter
//
// Status read-back stage on the host SPI clock. While the iCE is held in
// reset, this block watches the host bit stream for a status-read preamble.
// When it finds one, it answers with a 16-bit status frame on sdo, MSB first.
// The frame carries the decoder state, rail status, iCE done, a clear-on-read
// watchdog event count and a 3-bit frame sequence number. Once the iCE leaves
// reset, this block is held in reset and leaves the bus alone.
//
// Ports:
//   sclk          SPI clock; all state updates on posedge
//   n_ice_reset   asynchronous, active-high block reset
//   sdi           host serial data, sampled on posedge sclk
//   state[1:0]    command-decoder state
//   cs_pgood      power-good from the current-sense stage
//   main_en       main rail enable
//   ice_cdone     iCE CDONE
//   wdog_timeout  asynchronous watchdog timeout, active-high
//   sdo           status data to host (idles high)
//   sdo_oe        sdo driver enable, high only while a frame is sent
// -----------------------------------------------------------------------------
module atx_status_reporter #(
   parameter logic [7:0] PREAMBLE   = 8'h65,
   parameter logic [1:0] MARKER     = 2'b10,
   parameter int         WDOG_CNT_W = 4
) (
   input  logic       sclk,
   input  logic       n_ice_reset,
   input  logic       sdi,
   input  logic [1:0] state,
   input  logic       cs_pgood,
   input  logic       main_en,
   input  logic       ice_cdone,
   input  logic       wdog_timeout,
   output logic       sdo,
   output logic       sdo_oe
);

   typedef enum logic {HUNT, SEND} fsm_t;

   fsm_t                  fsm;
   // The oldest of the eight matched bits is never needed after the compare,
   // so only seven bits of history are stored.
   logic [6:0]            match_sr;
   logic [3:0]            bit_cnt;
   logic [15:0]           frame_sr;
   logic [WDOG_CNT_W-1:0] wdog_cnt;
   logic [2:0]            seq;
   logic                  wdog_p0, wdog_p1, wdog_p2;

   logic                  wdog_edge;
   logic                  match;
   logic [15:0]           frame_next;

   // Saturating increment of the watchdog event counter.
   function automatic logic [WDOG_CNT_W-1:0] sat_inc(input logic [WDOG_CNT_W-1:0] v);
      return (&v) ? v : v + WDOG_CNT_W'(1);
   endfunction

   // Frame assembly: each byte ends with an even-parity bit over its
   // preceding seven bits.
   function automatic logic [15:0] build_frame(input logic [1:0] st,
                                               input logic       pg,
                                               input logic       me,
                                               input logic       cd,
                                               input logic [3:0] wd,
                                               input logic [2:0] sq);
      logic [6:0] hi;
      logic [6:0] lo;
      hi = {MARKER, st, pg, me, cd};
      lo = {wd, sq};
      return {hi, ^hi, lo, ^lo};
   endfunction

   // Stage boundary: wdog_p0/p1 resynchronise the timeout, wdog_p2 delays it
   // one more cycle for the rising-edge detect.
   assign wdog_edge  = wdog_p1 & ~wdog_p2;
   assign match      = ({match_sr, sdi} == PREAMBLE);
   assign frame_next = build_frame(state, cs_pgood, main_en, ice_cdone,
                                   4'(wdog_cnt), seq);

   always_ff @(posedge sclk or posedge n_ice_reset) begin
      if (n_ice_reset) begin
         fsm      <= HUNT;
         match_sr <= '1;
         bit_cnt  <= '0;
         frame_sr <= '0;
         wdog_cnt <= '0;
         seq      <= '0;
         wdog_p0  <= 1'b0;
         wdog_p1  <= 1'b0;
         wdog_p2  <= 1'b0;
         sdo      <= 1'b1;
         sdo_oe   <= 1'b0;
      end else begin
         wdog_p0 <= wdog_timeout;
         wdog_p1 <= wdog_p0;
         wdog_p2 <= wdog_p1;

         // Clear-on-read: the snapshot takes the old count, while an edge
         // arriving on the match edge itself is kept as the new count.
         if (fsm == HUNT && match)
            wdog_cnt <= wdog_edge ? WDOG_CNT_W'(1) : '0;
         else if (wdog_edge)
            wdog_cnt <= sat_inc(wdog_cnt);

         case (fsm)
            HUNT: begin
               if (match) begin
                  fsm      <= SEND;
                  frame_sr <= frame_next;
                  sdo      <= frame_next[15];
                  sdo_oe   <= 1'b1;
                  bit_cnt  <= 4'd15;
                  seq      <= seq + 3'd1;
                  match_sr <= '1;
               end else begin
                  match_sr <= {match_sr[5:0], sdi};
               end
            end
            SEND: begin
               // Host bits during a frame are ignored. The next frame needs
               // eight fresh preamble bits after the frame ends.
               match_sr <= '1;
               if (bit_cnt == 4'd0) begin
                  fsm    <= HUNT;
                  sdo    <= 1'b1;
                  sdo_oe <= 1'b0;
               end else begin
                  bit_cnt  <= bit_cnt - 4'd1;
                  sdo      <= frame_sr[14];
                  frame_sr <= {frame_sr[14:0], 1'b0};
               end
            end
            default: fsm <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_atx_status_reporter.sv
module tb_atx_status_reporter;

   logic       sclk = 1'b0;
   logic       clk_run = 1'b0;
   logic       n_ice_reset = 1'b0;
   logic       sdi = 1'b1;
   logic [1:0] state = 2'b00;
   logic       cs_pgood = 1'b0;
   logic       main_en = 1'b0;
   logic       ice_cdone = 1'b0;
   logic       wdog_timeout = 1'b0;
   logic       sdo;
   logic       sdo_oe;

   int n_vec = 0;
   int n_fail = 0;

   logic [7:0] pre_v = 8'h65;

   atx_status_reporter dut (
      .sclk         (sclk),
      .n_ice_reset  (n_ice_reset),
      .sdi          (sdi),
      .state        (state),
      .cs_pgood     (cs_pgood),
      .main_en      (main_en),
      .ice_cdone    (ice_cdone),
      .wdog_timeout (wdog_timeout),
      .sdo          (sdo),
      .sdo_oe       (sdo_oe)
   );

   always begin
      #5;
      if (clk_run) sclk = ~sclk;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [1:0]  st;
      logic        pg;
      logic        me;
      logic        cd;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [15:0] model(input logic [1:0] st, input logic pg,
                                         input logic me, input logic cd,
                                         input logic [3:0] wd, input logic [2:0] sq);
      logic [15:0] f;
      f[15:14] = 2'b10;
      f[13:12] = st;
      f[11]    = pg;
      f[10]    = me;
      f[9]     = cd;
      f[8]     = f[15] ^ f[14] ^ f[13] ^ f[12] ^ f[11] ^ f[10] ^ f[9];
      f[7:4]   = wd;
      f[3:1]   = sq;
      f[0]     = f[7] ^ f[6] ^ f[5] ^ f[4] ^ f[3] ^ f[2] ^ f[1];
      return f;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Drive one bit ahead of the next posedge, then sample just after it.
   task automatic send_bit(input logic b);
      @(negedge sclk);
      sdi = b;
      @(posedge sclk);
      #1;
   endtask

   // lead ones, preamble, 15 frame edges, closing edge.
   task automatic read_frame(input int lead, input bit junk_in_send, input bit mid_change,
                             input int wd_rise_bit, output logic [15:0] got, output bit oe_ok);
      oe_ok = 1'b1;
      got   = '0;
      for (int i = 0; i < lead; i++) begin
         send_bit(1'b1);
         if (sdo_oe !== 1'b0 || sdo !== 1'b1) oe_ok = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         if (wd_rise_bit >= 0)
            wdog_timeout = (i == wd_rise_bit || i == wd_rise_bit + 1);
         send_bit(pre_v[7-i]);
         if (i < 7) begin
            if (sdo_oe !== 1'b0 || sdo !== 1'b1) oe_ok = 1'b0;
         end else begin
            if (sdo_oe !== 1'b1) oe_ok = 1'b0;
            got[15] = sdo;
         end
      end
      wdog_timeout = 1'b0;
      for (int k = 14; k >= 0; k--) begin
         if (mid_change && k == 12) begin
            state     = ~state;
            cs_pgood  = ~cs_pgood;
            main_en   = ~main_en;
            ice_cdone = ~ice_cdone;
         end
         send_bit((junk_in_send && k <= 7) ? pre_v[k] : 1'b1);
         if (sdo_oe !== 1'b1) oe_ok = 1'b0;
         got[k] = sdo;
      end
      send_bit(1'b1);
      if (sdo_oe !== 1'b0 || sdo !== 1'b1) oe_ok = 1'b0;
   endtask

   task automatic wdog_pulses(input int n);
      for (int p = 0; p < n; p++) begin
         for (int j = 0; j < 6; j++) begin
            wdog_timeout = (j < 2);
            send_bit(1'b1);
         end
      end
      wdog_timeout = 1'b0;
      for (int j = 0; j < 4; j++) send_bit(1'b1);
   endtask

   task automatic set_in(input logic [1:0] st, input logic pg, input logic me, input logic cd);
      state = st; cs_pgood = pg; main_en = me; ice_cdone = cd;
   endtask

   initial begin
      logic [15:0] got;
      bit          oe_ok;
      int          oe_seen;
      logic [7:0]  win;
      logic        b;
      logic [7:0]  cmd;
      logic [7:0]  post;

      vecs[0] = '{st: 2'b01, pg: 1'b1, me: 1'b1, cd: 1'b0, exp: 16'h9C00};
      vecs[1] = '{st: 2'b11, pg: 1'b1, me: 1'b1, cd: 1'b1, exp: 16'hBE03};
      vecs[2] = '{st: 2'b00, pg: 1'b0, me: 1'b0, cd: 1'b0, exp: 16'h8105};
      vecs[3] = '{st: 2'b10, pg: 1'b0, me: 1'b1, cd: 1'b1, exp: 16'hA606};
      vecs[4] = '{st: 2'b01, pg: 1'b0, me: 1'b0, cd: 1'b1, exp: 16'h9309};

      // Reset with the clock idle.
      #1 n_ice_reset = 1'b1;
      #2;
      check("reset_sdo", sdo, 1);
      check("reset_oe", sdo_oe, 0);
      #20 n_ice_reset = 1'b0;
      #30;
      check("idle_sdo", sdo, 1);
      check("idle_oe", sdo_oe, 0);

      clk_run = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(1'b1);

      // Table vectors, seq 0..4, no watchdog events.
      for (int v = 0; v < 5; v++) begin
         set_in(vecs[v].st, vecs[v].pg, vecs[v].me, vecs[v].cd);
         read_frame(2, 1'b0, 1'b0, -1, got, oe_ok);
         check($sformatf("vec%0d_frame", v), got, vecs[v].exp);
         check($sformatf("vec%0d_oe", v), oe_ok, 1);
      end

      // Reset asserted while bit 9 is on the wire.
      set_in(2'b11, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) send_bit(pre_v[7-i]);
      check("abort_oe_start", sdo_oe, 1);
      for (int i = 0; i < 6; i++) send_bit(1'b1);
      n_ice_reset = 1'b1;
      #1;
      check("abort_oe", sdo_oe, 0);
      check("abort_sdo", sdo, 1);
      @(posedge sclk);
      @(negedge sclk);
      n_ice_reset = 1'b0;
      oe_seen = 0;
      for (int i = 0; i < 20; i++) begin
         send_bit(1'b1);
         if (sdo_oe !== 1'b0) oe_seen++;
      end
      check("abort_no_resume", oe_seen, 0);

      // Watchdog count, clear-on-read, seq restarted from 0.
      wdog_pulses(3);
      set_in(2'b00, 1'b0, 1'b0, 1'b0);
      read_frame(1, 1'b0, 1'b0, -1, got, oe_ok);
      check("wdog3_frame", got, model(2'b00, 1'b0, 1'b0, 1'b0, 4'd3, 3'd0));
      check("wdog3_oe", oe_ok, 1);
      read_frame(1, 1'b0, 1'b0, -1, got, oe_ok);
      check("wdog_clr_field", got[7:4], 0);
      check("wdog_clr_seq", got[3:1], 1);
      check("wdog_clr_frame", got, model(2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 3'd1));
      wdog_pulses(20);
      set_in(2'b10, 1'b1, 1'b0, 1'b1);
      read_frame(1, 1'b0, 1'b0, -1, got, oe_ok);
      check("wdog_sat_frame", got, model(2'b10, 1'b1, 1'b0, 1'b1, 4'd15, 3'd2));

      // Watchdog edge detected on the match edge.
      read_frame(1, 1'b0, 1'b0, 5, got, oe_ok);
      check("wdog_same_edge_old", got, model(2'b10, 1'b1, 1'b0, 1'b1, 4'd0, 3'd3));
      read_frame(1, 1'b0, 1'b0, -1, got, oe_ok);
      check("wdog_same_edge_new", got, model(2'b10, 1'b1, 1'b0, 1'b1, 4'd1, 3'd4));

      // Nine back-to-back reads from a fresh seq; one frame has the preamble
      // sent inside its SEND window.
      @(negedge sclk);
      n_ice_reset = 1'b1;
      @(negedge sclk);
      n_ice_reset = 1'b0;
      set_in(2'b01, 1'b1, 1'b1, 1'b0);
      for (int r = 0; r < 9; r++) begin
         read_frame(0, (r == 3), 1'b0, -1, got, oe_ok);
         check($sformatf("seq_read%0d", r), got, model(2'b01, 1'b1, 1'b1, 1'b0, 4'd0, 3'(r % 8)));
         check($sformatf("seq_oe%0d", r), oe_ok, 1);
         if (r == 3) begin
            post = 8'b1001_0111;
            oe_seen = 0;
            for (int i = 0; i < 8; i++) begin
               send_bit(post[7-i]);
               if (sdo_oe !== 1'b0) oe_seen++;
            end
            check("overlap_no_premature", oe_seen, 0);
         end
      end

      // Host command preambles and junk without the status preamble.
      oe_seen = 0;
      win = 8'hFF;
      for (int c = 0; c < 4; c++) begin
         cmd = 8'h58 + 8'(c);
         for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            win = {win[6:0], 1'b1};
            if (sdo_oe !== 1'b0) oe_seen++;
         end
         for (int i = 0; i < 8; i++) begin
            send_bit(cmd[7-i]);
            win = {win[6:0], cmd[7-i]};
            if (sdo_oe !== 1'b0) oe_seen++;
         end
      end
      check("host_cmd_no_match", oe_seen, 0);
      oe_seen = 0;
      for (int i = 0; i < 96; i++) begin
         b = 1'($urandom_range(0, 1));
         if ({win[6:0], b} == pre_v) b = ~b;
         win = {win[6:0], b};
         send_bit(b);
         if (sdo_oe !== 1'b0) oe_seen++;
      end
      check("junk_no_match", oe_seen, 0);

      // Inputs changed while the frame is in flight.
      set_in(2'b10, 1'b0, 1'b1, 1'b0);
      read_frame(8, 1'b0, 1'b1, -1, got, oe_ok);
      check("snapshot_frame", got, model(2'b10, 1'b0, 1'b1, 1'b0, 4'd0, 3'd1));
      check("snapshot_oe", oe_ok, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
